// File: rtl/gf_div.sv
// GF(2^8) divider / inverter over x^8+x^4+x^3+x^2+1.
// The inverse of b is formed as b^254 by seven square-and-multiply steps,
// followed by one multiply by the dividend (or by 1 in inverse mode).
module gf_div #(
    parameter int         IO_WIDTH = 8,
    parameter logic [7:0] PP_CHAR  = 8'h1D
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                mode_i,
    input  logic [IO_WIDTH-1:0] op_a_i,
    input  logic [IO_WIDTH-1:0] op_b_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [IO_WIDTH-1:0] result_o,
    output logic                div_zero_o,
    output logic                busy_o
);

    localparam int PW = 2 * IO_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [IO_WIDTH-1:0] a_q;
    logic [IO_WIDTH-1:0] sq;
    logic [IO_WIDTH-1:0] acc;
    logic [IO_WIDTH-1:0] result_q;
    logic [IO_WIDTH-1:0] sq_next;
    logic [2:0]          cnt;
    logic                zero_q;
    logic                accept;

    // Reduce a carry-less product by folding bits k=14..8 down, high to low.
    function automatic logic [IO_WIDTH-1:0] gf_reduce(input logic [PW-1:0] prod);
        logic [PW-1:0] p;
        p = prod;
        for (int k = PW - 1; k >= IO_WIDTH; k--) begin
            if (p[k]) p = p ^ (PW'({1'b1, PP_CHAR}) << (k - IO_WIDTH));
        end
        return p[IO_WIDTH-1:0];
    endfunction

    // Carry-less multiply followed by field reduction.
    function automatic logic [IO_WIDTH-1:0] gf_mul(input logic [IO_WIDTH-1:0] x,
                                                   input logic [IO_WIDTH-1:0] y);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < IO_WIDTH; i++) begin
            if (y[i]) p = p ^ (PW'(x) << i);
        end
        return gf_reduce(p);
    endfunction

    // Squaring in characteristic 2 just spreads the bits to even positions.
    function automatic logic [IO_WIDTH-1:0] gf_sq(input logic [IO_WIDTH-1:0] x);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < IO_WIDTH; i++) begin
            p[2*i] = x[i];
        end
        return gf_reduce(p);
    endfunction

    assign accept      = in_valid_i && (state == IDLE);
    assign sq_next     = gf_sq(sq);
    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign busy_o      = (state == EXP) || (state == MUL);
    assign result_o    = result_q;
    assign div_zero_o  = zero_q && (state == DONE);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic: fixed 7 exponent steps, one multiply, then hold until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid_i)  state_next = EXP;
            EXP:  if (cnt == 3'd6) state_next = MUL;
            MUL:                   state_next = DONE;
            DONE: if (out_ready_i) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Operand capture, square-and-multiply datapath and result register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q      <= '0;
            sq       <= '0;
            acc      <= '0;
            cnt      <= '0;
            zero_q   <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                a_q    <= mode_i ? IO_WIDTH'(1) : op_a_i;
                sq     <= op_b_i;
                acc    <= IO_WIDTH'(1);
                cnt    <= '0;
                zero_q <= (op_b_i == '0);
            end else if (state == EXP) begin
                sq  <= sq_next;
                acc <= gf_mul(acc, sq_next);
                cnt <= cnt + 3'd1;
            end else if (state == MUL) begin
                result_q <= gf_mul(acc, a_q);
            end
        end
    end

endmodule

// File: tb/tb_gf_div.sv
// Self-checking bench for gf_div: scoreboard of expected results built from
// an independent shift-and-xor field model and a brute-force inverse table.
module tb_gf_div;

    typedef struct packed {
        logic [7:0] res;
        logic       dz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       mode = 1'b0;
    logic [7:0] op_a = '0;
    logic [7:0] op_b = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       div_zero;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    exp_t       sb[$];
    logic [7:0] inv_tab[256];

    gf_div #(.IO_WIDTH(8), .PP_CHAR(8'h1D)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .div_zero_o  (div_zero),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    // Russian-peasant multiply with xtime reduction by 0x11D.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r, xx, yy;
        r = '0; xx = x; yy = y;
        for (int i = 0; i < 8; i++) begin
            if (yy[0]) r = r ^ xx;
            yy = yy >> 1;
            xx = xx[7] ? ((xx << 1) ^ 8'h1D) : (xx << 1);
        end
        return r;
    endfunction

    // Drive one request, queue its expectation, wait (bounded) for the output.
    task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] res, output logic dz, output int lat);
        exp_t e;
        e.dz  = (b == 8'h00);
        e.res = (b == 8'h00) ? 8'h00 : ref_mul(m ? 8'h01 : a, inv_tab[b]);
        @(negedge clk);
        mode = m; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back(e);
        in_valid = 1'b0;
        mode = $urandom_range(0, 1);
        op_a = $urandom_range(0, 255);
        op_b = $urandom_range(0, 255);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        dz  = div_zero;
        if (out_ready && out_valid) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h want=00", result); end
        total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_div_zero got=%b want=0", div_zero); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed cases with literal expected values alongside the scoreboard.
    task automatic test_directed();
        logic [7:0] tm, ta, tb, tr, tz;
        logic [7:0] res; logic dz; int lat; exp_t e;
        logic [39:0] tab [8];
        tab[0] = {8'h01, 8'h00, 8'h02, 8'h8E, 8'h00};
        tab[1] = {8'h01, 8'h00, 8'h01, 8'h01, 8'h00};
        tab[2] = {8'h00, 8'h1D, 8'h02, 8'h80, 8'h00};
        tab[3] = {8'h00, 8'h04, 8'h02, 8'h02, 8'h00};
        tab[4] = {8'h00, 8'h53, 8'h01, 8'h53, 8'h00};
        tab[5] = {8'h00, 8'h02, 8'h02, 8'h01, 8'h00};
        tab[6] = {8'h00, 8'h37, 8'h00, 8'h00, 8'h01};
        tab[7] = {8'h00, 8'h00, 8'h45, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            {tm, ta, tb, tr, tz} = tab[i];
            run_op(tm[0], ta, tb, res, dz, lat);
            e = sb.pop_front();
            total++; if (res !== tr) begin bad++; $display("FAIL directed%0d_result got=%h want=%h", i, res, tr); end
            total++; if (dz !== tz[0]) begin bad++; $display("FAIL directed%0d_div_zero got=%b want=%b", i, dz, tz[0]); end
            total++; if ({res, dz} !== {e.res, e.dz}) begin bad++; $display("FAIL directed%0d_scoreboard got=%h/%b want=%h/%b", i, res, dz, e.res, e.dz); end
            total++; if (lat !== 8) begin bad++; $display("FAIL directed%0d_latency got=%0d want=8", i, lat); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] res; logic dz; int lat; exp_t e; int seen;
        out_ready = 1'b0;
        run_op(1'b0, 8'h1D, 8'h02, res, dz, lat);
        e = sb.pop_front();
        total++; if ({res, dz} !== {e.res, e.dz}) begin bad++; $display("FAIL bp_result got=%h/%b want=%h/%b", res, dz, e.res, e.dz); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; mode = 1'b0; op_a = 8'h11; op_b = 8'h22;
            @(posedge clk); #1;
            total++; if ({out_valid, in_ready, result, div_zero} !== {1'b1, 1'b0, e.res, 1'b0})
                begin bad++; $display("FAIL bp_hold%0d got v=%b r=%b res=%h dz=%b want v=1 r=0 res=%h dz=0", i, out_valid, in_ready, result, div_zero, e.res); end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if ({out_valid, in_ready, busy} !== 3'b010) begin bad++; $display("FAIL bp_release got v=%b r=%b busy=%b want v=0 r=1 busy=0", out_valid, in_ready, busy); end
        total++; if (result !== e.res) begin bad++; $display("FAIL bp_result_kept got=%h want=%h", result, e.res); end
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (out_valid || busy) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL bp_ignored_request got=%0d active cycles want=0", seen); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] res; logic dz; int lat; exp_t e; int seen;
        @(negedge clk);
        mode = 1'b0; op_a = 8'h53; op_b = 8'h07; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 8'h00})
            begin bad++; $display("FAIL rstmid_state got r=%b v=%b busy=%b res=%h want r=1 v=0 busy=0 res=00", in_ready, out_valid, busy, result); end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (out_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_discard got=%0d valid cycles want=0", seen); end
        run_op(1'b0, 8'h53, 8'h07, res, dz, lat);
        e = sb.pop_front();
        total++; if ({res, dz} !== {e.res, e.dz}) begin bad++; $display("FAIL rstmid_after got=%h/%b want=%h/%b", res, dz, e.res, e.dz); end
        total++; if (lat !== 8) begin bad++; $display("FAIL rstmid_latency got=%0d want=8", lat); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] res; logic dz; int lat; exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, 8'(8'h30 + i), 8'(8'h05 + 3 * i), res, dz, lat);
            e = sb.pop_front();
            total++; if ({res, dz, lat} !== {e.res, e.dz, 32'd8}) begin bad++; $display("FAIL b2b%0d got=%h/%b lat=%0d want=%h/%b lat=8", i, res, dz, lat, e.res, e.dz); end
            total++; if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL b2b%0d_idle got r=%b v=%b want r=1 v=0", i, in_ready, out_valid); end
        end
    endtask

    task automatic test_exhaustive_inverse();
        logic [7:0] res; logic dz; int lat; exp_t e; int errs;
        errs = 0;
        for (int b = 1; b < 256; b++) begin
            run_op(1'b1, 8'($urandom_range(0, 255)), 8'(b), res, dz, lat);
            e = sb.pop_front();
            total++;
            if (ref_mul(8'(b), res) !== 8'h01 || res !== e.res || dz !== 1'b0 || lat !== 8) begin
                bad++; errs++;
                if (errs < 6) $display("FAIL inverse b=%h got=%h dz=%b lat=%0d want=%h dz=0 lat=8", b[7:0], res, dz, lat, e.res);
            end
        end
    endtask

    task automatic test_random_divide();
        logic [7:0] a, b, res; logic dz; int lat; exp_t e;
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(1, 255);
            run_op(1'b0, a, b, res, dz, lat);
            e = sb.pop_front();
            total++;
            if (ref_mul(res, b) !== a || res !== e.res || dz !== 1'b0 || lat !== 8) begin
                bad++; $display("FAIL random a=%h b=%h got=%h dz=%b lat=%0d want=%h dz=0 lat=8", a, b, res, dz, lat, e.res);
            end
        end
        total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
    endtask

    initial begin
        inv_tab[0] = 8'h00;
        for (int b = 1; b < 256; b++) begin
            inv_tab[b] = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (ref_mul(8'(b), 8'(x)) == 8'h01) inv_tab[b] = 8'(x);
            end
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_exhaustive_inverse();
        test_random_divide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
